// File: rtl/rv32_imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The master drives program bytes and watches the memory writes. The slave is
// the loader, which consumes the bytes and issues the memory writes.
interface rv32_imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/rv32_imem_loader.sv
// Boot-time program loader for the RV32 core.
// Input stream format: a 32-bit little-endian word count N, then N
// little-endian instruction words. Each word is written to instruction memory
// in order, starting at address 0. When the last word is written, the loader
// releases the core from reset. A count larger than the memory is rejected,
// and the core then stays in reset. All outputs are registered.
module rv32_imem_loader #(
  parameter int IMEM_WORDS = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  rv32_imem_loader_if.slave  bus,
  output logic               core_reset_n,
  output logic               done,
  output logic               error
);

  typedef enum logic [1:0] {HDR, LOAD, RUN, ERR} state_t;

  state_t            state_q, state_n;
  logic [1:0]        bcnt_q, bcnt_n;      // byte position within header/word
  logic [31:0]       cnt_q, cnt_n;        // word count N (shifted in LSB first)
  logic [ADDR_W-1:0] widx_q, widx_n;      // next word address to write
  logic [23:0]       wbuf_q, wbuf_n;      // first three bytes of current word
  logic              rdy_q, rdy_n;
  logic              we_q, we_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [31:0]       wdata_q, wdata_n;
  logic              crn_q, crn_n;
  logic              done_q, done_n;
  logic              err_q, err_n;

  logic              fire;
  logic [31:0]       hdr_word;
  logic              last_word;

  // in_ready is registered, so a byte is taken only when it was already
  // advertised for this cycle.
  assign fire      = bus.in_valid && rdy_q;
  // The header shifts in LSB first. With the 4th byte on the input, the full
  // count is {in_data, upper three bytes already shifted in}.
  assign hdr_word  = {bus.in_data, cnt_q[31:8]};
  assign last_word = ({{(32-ADDR_W){1'b0}}, widx_q} == (cnt_q - 32'd1));

  assign bus.in_ready   = rdy_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign core_reset_n   = crn_q;
  assign done           = done_q;
  assign error          = err_q;

  // State and output registers; synchronous reset discards any partial bytes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= HDR;
      bcnt_q  <= '0;
      cnt_q   <= '0;
      widx_q  <= '0;
      wbuf_q  <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      crn_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      bcnt_q  <= bcnt_n;
      cnt_q   <= cnt_n;
      widx_q  <= widx_n;
      wbuf_q  <= wbuf_n;
      rdy_q   <= rdy_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      crn_q   <= crn_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  // Next-state logic and next values of all outputs. When no byte is
  // offered, every counter holds its value.
  always_comb begin
    state_n = state_q;
    bcnt_n  = bcnt_q;
    cnt_n   = cnt_q;
    widx_n  = widx_q;
    wbuf_n  = wbuf_q;
    we_n    = 1'b0;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    crn_n   = crn_q;
    done_n  = done_q;
    err_n   = err_q;

    case (state_q)
      HDR: begin
        if (fire) begin
          cnt_n  = hdr_word;
          bcnt_n = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (hdr_word == 32'd0) begin
              state_n = RUN;
              crn_n   = 1'b1;
              done_n  = 1'b1;
            end else if (hdr_word > 32'(IMEM_WORDS)) begin
              state_n = ERR;
              err_n   = 1'b1;
            end else begin
              state_n = LOAD;
              widx_n  = '0;
            end
          end
        end
      end
      LOAD: begin
        if (fire) begin
          wbuf_n = {bus.in_data, wbuf_q[23:8]};
          bcnt_n = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_n    = 1'b1;
            addr_n  = widx_q;
            wdata_n = {bus.in_data, wbuf_q};
            if (last_word) begin
              // The core comes out of reset in the same cycle that the
              // final write is presented to memory.
              state_n = RUN;
              crn_n   = 1'b1;
              done_n  = 1'b1;
            end else begin
              widx_n = widx_q + 1'b1;
            end
          end
        end
      end
      RUN:     state_n = RUN;
      ERR:     state_n = ERR;
      default: state_n = HDR;
    endcase
  end

  // in_ready follows the next state, so it is already valid on the first
  // cycle of HDR or LOAD and already cleared on the first cycle of RUN or ERR.
  always_comb begin
    rdy_n = (state_n == HDR) || (state_n == LOAD);
  end

endmodule

// File: tb/tb_rv32_imem_loader.sv
// Self-checking bench for rv32_imem_loader. Randomized byte streams are checked
// against the expected write list built from the stream format.
module tb_rv32_imem_loader;
  localparam int IMEM_WORDS = 1024;
  localparam int ADDR_W     = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic core_reset_n, done, error;

  rv32_imem_loader_if #(.ADDR_W(ADDR_W)) bus();

  rv32_imem_loader #(.IMEM_WORDS(IMEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .core_reset_n(core_reset_n), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Write log, sampled 1 time unit after each rising edge.
  int                cyc = 0;
  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];
  int                wc[$];
  int                done_cyc = -1;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.imem_we === 1'b1) begin
      wa.push_back(bus.imem_addr);
      wd.push_back(bus.imem_wdata);
      wc.push_back(cyc);
    end
    if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  end

  logic [7:0]  byte_q[$];
  logic [31:0] exp_words[$];

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete(); done_cyc = -1;
  endtask

  // Reference model: header N (LE) followed by each expected word (LE).
  task automatic build(input int unsigned n);
    byte_q.delete();
    for (int b = 0; b < 4; b++) byte_q.push_back(8'(n >> (8*b)));
    foreach (exp_words[i])
      for (int b = 0; b < 4; b++) byte_q.push_back(8'(exp_words[i] >> (8*b)));
  endtask

  // Returns the number of differences between the logged writes and the
  // expected list, in which word i goes to address i.
  function automatic int bad_writes();
    int b = 0;
    if (wa.size() != exp_words.size()) b++;
    for (int i = 0; i < wa.size() && i < exp_words.size(); i++)
      if (wa[i] !== ADDR_W'(i) || wd[i] !== exp_words[i]) b++;
    return b;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    clear_log();
  endtask

  // Offer byte_q at the given duty (percent). Returns the cycle number of
  // the edge that took the last byte.
  task automatic send(input int duty, output int acc_cyc);
    int i = 0;
    int n = 0;
    int lim;
    lim = 40 * byte_q.size() + 100;
    while (i < byte_q.size() && n < lim) begin
      @(negedge clk); n++;
      bus.in_data  = byte_q[i];
      bus.in_valid = ($urandom_range(99) < duty);
      if (bus.in_valid && bus.in_ready) i++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    acc_cyc = cyc;
    tot_cnt++;
    if (i != byte_q.size()) $display("FAIL send_timeout accepted=%0d required=%0d", i, byte_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = 8'h00; reset_n = 1'b0;
    repeat (2) @(negedge clk);
    tot_cnt++;
    if ({bus.in_ready, bus.imem_we, core_reset_n, done, error} !== 5'b0)
      $display("FAIL reset_flags got=%b want=00000", {bus.in_ready, bus.imem_we, core_reset_n, done, error});
    else pass_cnt++;
    tot_cnt++;
    if (bus.imem_addr !== '0) $display("FAIL reset_addr got=%h want=0", bus.imem_addr); else pass_cnt++;
    tot_cnt++;
    if (bus.imem_wdata !== 32'h0) $display("FAIL reset_wdata got=%h want=0", bus.imem_wdata); else pass_cnt++;
    reset_n = 1'b1;
    clear_log();
    @(negedge clk);
    tot_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL ready_after_reset got=%b want=1", bus.in_ready); else pass_cnt++;
  endtask

  task automatic test_basic();
    int ac;
    exp_words = '{32'h0000_0013, 32'h0010_0093};
    build(2);
    send(100, ac);
    repeat (3) @(negedge clk);
    tot_cnt++;
    if (bad_writes() !== 0) $display("FAIL basic_writes bad=%0d want=0", bad_writes()); else pass_cnt++;
    tot_cnt++;
    if ((wc.size() == 2 ? wc[1] : -1) !== ac) $display("FAIL basic_last_we_cyc got=%0d want=%0d", (wc.size() == 2 ? wc[1] : -1), ac);
    else pass_cnt++;
    tot_cnt++;
    if (done_cyc !== ac) $display("FAIL basic_done_cyc got=%0d want=%0d", done_cyc, ac); else pass_cnt++;
    tot_cnt++;
    if ({core_reset_n, done, error, bus.in_ready} !== 4'b1100)
      $display("FAIL basic_run_flags got=%b want=1100", {core_reset_n, done, error, bus.in_ready});
    else pass_cnt++;
  endtask

  task automatic test_zero();
    int ac;
    apply_reset();
    exp_words.delete();
    build(0);
    send(100, ac);
    tot_cnt++;
    if (done_cyc !== ac) $display("FAIL zero_done_cyc got=%0d want=%0d", done_cyc, ac); else pass_cnt++;
    // Bytes offered in RUN must be ignored.
    repeat (8) begin
      @(negedge clk); bus.in_valid = 1'b1; bus.in_data = 8'($urandom);
    end
    @(negedge clk); bus.in_valid = 1'b0;
    tot_cnt++;
    if (wa.size() !== 0) $display("FAIL zero_no_we got=%0d want=0", wa.size()); else pass_cnt++;
    tot_cnt++;
    if ({core_reset_n, done, bus.in_ready} !== 3'b110)
      $display("FAIL zero_flags got=%b want=110", {core_reset_n, done, bus.in_ready});
    else pass_cnt++;
  endtask

  task automatic test_err();
    int ac;
    apply_reset();
    exp_words.delete();
    build(IMEM_WORDS + 1);
    send(100, ac);
    repeat (3) @(negedge clk);
    tot_cnt++;
    if ({error, core_reset_n, done, bus.in_ready} !== 4'b1000)
      $display("FAIL err_flags got=%b want=1000", {error, core_reset_n, done, bus.in_ready});
    else pass_cnt++;
    tot_cnt++;
    if (wa.size() !== 0) $display("FAIL err_no_we got=%0d want=0", wa.size()); else pass_cnt++;
  endtask

  task automatic test_stall();
    int ac;
    int adj = 0;
    apply_reset();
    exp_words.delete();
    for (int i = 0; i < 3; i++) exp_words.push_back($urandom);
    build(3);
    send(50, ac);
    repeat (3) @(negedge clk);
    tot_cnt++;
    if (bad_writes() !== 0) $display("FAIL stall_writes bad=%0d want=0", bad_writes()); else pass_cnt++;
    for (int i = 1; i < wc.size(); i++) if (wc[i] == wc[i-1] + 1) adj++;
    tot_cnt++;
    if (adj !== 0) $display("FAIL stall_we_width adjacent=%0d want=0", adj); else pass_cnt++;
    tot_cnt++;
    if (done_cyc !== ac) $display("FAIL stall_done_cyc got=%0d want=%0d", done_cyc, ac); else pass_cnt++;
  endtask

  task automatic test_random();
    int ac;
    int n;
    for (int k = 0; k < 4; k++) begin
      apply_reset();
      n = $urandom_range(8, 1);
      exp_words.delete();
      for (int i = 0; i < n; i++) exp_words.push_back($urandom);
      build(n);
      send($urandom_range(100, 30), ac);
      repeat (2) @(negedge clk);
      tot_cnt++;
      if (bad_writes() !== 0) $display("FAIL rand%0d_writes bad=%0d want=0", k, bad_writes()); else pass_cnt++;
      tot_cnt++;
      if (done_cyc !== ac) $display("FAIL rand%0d_done_cyc got=%0d want=%0d", k, done_cyc, ac); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int ac;
    apply_reset();
    exp_words = '{32'($urandom), 32'($urandom)};
    build(2);
    while (byte_q.size() > 10) void'(byte_q.pop_back());
    send(70, ac);
    tot_cnt++;
    if (wa.size() !== 1) $display("FAIL mid_pre_writes got=%0d want=1", wa.size()); else pass_cnt++;
    apply_reset();
    exp_words = '{32'hDEAD_BEEF};
    build(1);
    send(100, ac);
    repeat (2) @(negedge clk);
    tot_cnt++;
    if (bad_writes() !== 0) $display("FAIL mid_writes bad=%0d want=0", bad_writes()); else pass_cnt++;
    tot_cnt++;
    if (done_cyc !== ac) $display("FAIL mid_done_cyc got=%0d want=%0d", done_cyc, ac); else pass_cnt++;
  endtask

  task automatic test_full();
    int ac;
    apply_reset();
    exp_words.delete();
    for (int i = 0; i < IMEM_WORDS; i++) exp_words.push_back(32'(i));
    build(IMEM_WORDS);
    send(100, ac);
    repeat (3) @(negedge clk);
    tot_cnt++;
    if (bad_writes() !== 0) $display("FAIL full_writes bad=%0d want=0", bad_writes()); else pass_cnt++;
    tot_cnt++;
    if ((wa.size() > 0 ? int'(wa[$]) : -1) !== IMEM_WORDS - 1)
      $display("FAIL full_last_addr got=%0d want=%0d", (wa.size() > 0 ? int'(wa[$]) : -1), IMEM_WORDS - 1);
    else pass_cnt++;
    tot_cnt++;
    if ({done, core_reset_n} !== 2'b11) $display("FAIL full_done got=%b want=11", {done, core_reset_n}); else pass_cnt++;
  endtask

  task automatic test_run_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    tot_cnt++;
    if ({core_reset_n, done} !== 2'b00) $display("FAIL run_reset got=%b want=00", {core_reset_n, done}); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_err();
    test_stall();
    test_random();
    test_reset_mid();
    test_full();
    test_run_reset();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/rv32_imem_loader.md
RV32_IMEM_LOADER -- requirements
Module: rv32_imem_loader

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 1024, instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 10, word-address width, with 2**ADDR_W >= IMEM_WORDS.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  upstream byte valid.
REQ-006 SHALL have port in_data  input  8  upstream program byte.
REQ-007 SHALL have port in_ready  output  1  loader accepts a byte; a transfer occurs on a rising edge with in_valid && in_ready.
REQ-008 SHALL have port imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port imem_addr  output  ADDR_W  instruction-memory word address.
REQ-010 SHALL have port imem_wdata  output  32  instruction word.
REQ-011 SHALL have port core_reset_n  output  1  active-low reset driven to rv32_single_cycle_top.reset_n.
REQ-012 SHALL have port done  output  1  program loaded, core running.
REQ-013 SHALL have port error  output  1  header rejected, core held in reset.

Function
REQ-014 SHALL implement states HDR, LOAD, RUN, ERR; all outputs registered.
REQ-015 Stream format SHALL be a 4-byte little-endian word count N, then N words of 4 bytes each, little-endian (first byte is bits [7:0]).
REQ-016 in_ready SHALL be 1 in HDR and LOAD and 0 in RUN and ERR.
REQ-017 HDR SHALL collect 4 bytes into a 32-bit count register using a 2-bit byte counter.
REQ-018 On the edge accepting the 4th header byte: N == 0 -> RUN; N > IMEM_WORDS -> ERR; otherwise -> LOAD with the word index set to 0.
REQ-019 LOAD SHALL assemble bytes using a 2-bit byte counter that wraps from 3 to 0.
REQ-020 On the edge accepting the 4th byte of a word, SHALL set imem_we=1, imem_addr=word index, and imem_wdata=assembled word, all visible in the following cycle.
REQ-021 imem_we SHALL be 1 for exactly one cycle per word and SHALL be 0 otherwise.
REQ-022 The word index SHALL increment after each word write and SHALL never exceed IMEM_WORDS-1.
REQ-023 On the edge writing word N-1, state SHALL go to RUN.
REQ-024 core_reset_n SHALL go to 1 and done SHALL go to 1 on the edge on which RUN is entered, that is, in the same cycle that the last imem_we is visible.
REQ-025 The core SHALL therefore leave reset on the edge after the last memory write.
REQ-026 core_reset_n SHALL be 0 in HDR, LOAD, and ERR.
REQ-027 RUN and ERR SHALL be terminal until reset_n is asserted; input bytes offered in these states SHALL be ignored.
REQ-028 Gaps in in_valid SHALL stall assembly without loss; the byte counters SHALL hold their values.
REQ-029 The 2-bit byte counters SHALL wrap from 3 to 0 without sticky or overflow state.

Reset
REQ-030 When reset_n=0 at a rising edge: state=HDR, byte counters=0, word index=0, count=0, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset_n=0, done=0, error=0.
REQ-031 in_ready SHALL rise on the first edge with reset_n=1.
REQ-032 Reset asserted mid-header or mid-word SHALL discard partial bytes.
REQ-033 Reset asserted mid-load SHALL discard partial words; already-written memory words SHALL be left as written, and no further imem_we SHALL occur.
REQ-034 Reset asserted in RUN SHALL return core_reset_n to 0 on the same edge.

Verification
REQ-035 Bench SHALL cover: stream 02 00 00 00, 13 00 00 00, 93 00 10 00 -> writes [0]=0x00000013, [1]=0x00100093; core_reset_n=1 and done=1 one edge after the 2nd write.
REQ-036 Bench SHALL cover: header 00 00 00 00 -> no imem_we; done=1 and core_reset_n=1 in the cycle after the 4th byte; in_ready=0 afterwards.
REQ-037 Bench SHALL cover: header 01 04 00 00 (N=1025) with IMEM_WORDS=1024 -> error=1, core_reset_n stays 0, no imem_we, in_ready=0.
REQ-038 Bench SHALL cover: N=3 with in_valid toggled randomly (about 50% duty) -> exactly 3 writes to addresses 0,1,2 with correct data, each imem_we one cycle wide.
REQ-039 Bench SHALL cover: reset_n=0 for one cycle after the 2nd byte of word 1, then a full new stream with N=1 and word 0xDEADBEEF -> single write [0]=0xDEADBEEF, done=1.
REQ-040 Bench SHALL cover: N=IMEM_WORDS with words equal to their index -> last write to address IMEM_WORDS-1, no address wrap, done=1.
